// File: rtl/estagio_busca.sv
// estagio_busca: MIPS instruction-fetch stage owning the PC, the IF/ID register and the imem req/ready handshake
// Ports: clock/reset (sync, active-high); PCEscreve/IFIDEscreve stall controls from the hazard unit;
//        branch_taken/branch_target redirect; imem_req/imem_addr/imem_ready/imem_data memory handshake;
//        IFID_instr/IFID_pc4/IFID_valid registered outputs; IFID_rs/IFID_rt decoded fields; fetch_stall.
module estagio_busca #(
    parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        PCEscreve,
    input  logic        IFIDEscreve,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_pc4,
    output logic        IFID_valid,
    output logic [4:0]  IFID_rs,
    output logic [4:0]  IFID_rt,
    output logic        fetch_stall
);
    localparam logic [1:0] BUSCA    = 2'd0;
    localparam logic [1:0] ESPERA   = 2'd1;
    localparam logic [1:0] DESCARTE = 2'd2;
    logic [1:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic [31:0] hold_instr_q, hold_instr_d, hold_pc4_q, hold_pc4_d;
    logic [31:0] instr_q, instr_d, pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        avanca;
    logic [31:0] target, req_pc4;
    assign avanca      = PCEscreve & IFIDEscreve;
    assign target      = {branch_target[31:2], 2'b00};
    assign req_pc4     = req_addr_q + 32'd4;
    assign imem_req    = !reset && state_q != ESPERA;
    assign imem_addr   = req_addr_q;
    assign IFID_instr  = instr_q;
    assign IFID_pc4    = pc4_q;
    assign IFID_valid  = valid_q;
    assign IFID_rs     = instr_q[25:21];
    assign IFID_rt     = instr_q[20:16];
    assign fetch_stall = (state_q == BUSCA && !imem_ready) || state_q == DESCARTE;
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_addr_d   = req_addr_q;
        hold_instr_d = hold_instr_q;
        hold_pc4_d   = hold_pc4_q;
        instr_d      = instr_q;
        pc4_d        = pc4_q;
        valid_d      = valid_q;
        if (branch_taken) begin
            pc_d         = target;
            instr_d      = '0;
            pc4_d        = '0;
            valid_d      = 1'b0;
            hold_instr_d = '0;
            hold_pc4_d   = '0;
            // An unanswered request must stay on the bus until ready; drain it first.
            if (state_q != ESPERA && !imem_ready) begin
                state_d = DESCARTE;
            end else begin
                req_addr_d = target;
                state_d    = BUSCA;
            end
        end else begin
            case (state_q)
                BUSCA: begin
                    if (imem_ready && avanca) begin
                        instr_d    = imem_data;
                        pc4_d      = req_pc4;
                        valid_d    = 1'b1;
                        pc_d       = req_pc4;
                        req_addr_d = req_pc4;
                    end else if (imem_ready) begin
                        hold_instr_d = imem_data;
                        hold_pc4_d   = req_pc4;
                        state_d      = ESPERA;
                    end else if (avanca) begin
                        instr_d = '0;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                    end
                end
                ESPERA: begin
                    if (avanca) begin
                        instr_d    = hold_instr_q;
                        pc4_d      = hold_pc4_q;
                        valid_d    = 1'b1;
                        pc_d       = hold_pc4_q;
                        req_addr_d = hold_pc4_q;
                        state_d    = BUSCA;
                    end
                end
                DESCARTE: begin
                    if (imem_ready) begin
                        req_addr_d = pc_q;
                        state_d    = BUSCA;
                    end
                    if (avanca) begin
                        instr_d = '0;
                        pc4_d   = '0;
                        valid_d = 1'b0;
                    end
                end
                default: state_d = BUSCA;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= BUSCA;
            pc_q         <= PC_RESET;
            req_addr_q   <= PC_RESET;
            hold_instr_q <= '0;
            hold_pc4_q   <= '0;
            instr_q      <= '0;
            pc4_q        <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_addr_q   <= req_addr_d;
            hold_instr_q <= hold_instr_d;
            hold_pc4_q   <= hold_pc4_d;
            instr_q      <= instr_d;
            pc4_q        <= pc4_d;
            valid_q      <= valid_d;
        end
    end
endmodule

// File: tb/tb_estagio_busca.sv
// tb_estagio_busca: directed scenarios plus randomized traffic checked against a behavioural fetch model
module tb_estagio_busca;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        pc_esc = 1'b1, ifid_esc = 1'b1, br = 1'b0, rdy = 1'b0;
    logic [31:0] bt = '0;
    logic        imem_req, IFID_valid, fetch_stall;
    logic [31:0] imem_addr, imem_data, IFID_instr, IFID_pc4;
    logic [4:0]  IFID_rs, IFID_rt;
    int          n_cmp = 0, n_err = 0;
    logic        m_buf = 0, m_drop = 0, m_valid = 0;
    logic [31:0] m_pc = 0, m_addr = 0, m_bi = 0, m_bp = 0, m_instr = 0, m_pc4 = 0;

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]} ^ 32'h0123_4567;
    endfunction

    assign imem_data = rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    estagio_busca dut (
        .clock(clock), .reset(reset), .PCEscreve(pc_esc), .IFIDEscreve(ifid_esc),
        .branch_taken(br), .branch_target(bt), .imem_ready(rdy), .imem_data(imem_data),
        .imem_req(imem_req), .imem_addr(imem_addr), .IFID_instr(IFID_instr), .IFID_pc4(IFID_pc4),
        .IFID_valid(IFID_valid), .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .fetch_stall(fetch_stall)
    );

    // Behavioural model: one outstanding fetch address, an optional parked word, and a "draining stale fetch" flag.
    task automatic model_step();
        logic [31:0] t;
        t = {bt[31:2], 2'b00};
        if (reset) begin
            m_pc = 0; m_addr = 0; m_buf = 0; m_drop = 0; m_bi = 0; m_bp = 0;
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end else if (br) begin
            m_pc = t; m_instr = 0; m_pc4 = 0; m_valid = 0;
            if (!m_buf && !rdy) m_drop = 1;
            else begin m_addr = t; m_drop = 0; end
            m_buf = 0;
        end else if (m_buf) begin
            if (pc_esc && ifid_esc) begin
                m_instr = m_bi; m_pc4 = m_bp; m_valid = 1; m_pc = m_bp; m_addr = m_bp; m_buf = 0;
            end
        end else if (m_drop) begin
            if (rdy) begin m_addr = m_pc; m_drop = 0; end
            if (pc_esc && ifid_esc) begin m_instr = 0; m_pc4 = 0; m_valid = 0; end
        end else if (rdy) begin
            if (pc_esc && ifid_esc) begin
                m_instr = mem_word(m_addr); m_pc4 = m_addr + 4; m_valid = 1;
                m_addr = m_addr + 4; m_pc = m_addr;
            end else begin
                m_buf = 1; m_bi = mem_word(m_addr); m_bp = m_addr + 4;
            end
        end else if (pc_esc && ifid_esc) begin
            m_instr = 0; m_pc4 = 0; m_valid = 0;
        end
    endtask

    task automatic set_in(input logic r, input logic av, input logic b, input logic [31:0] t, input logic rd);
        @(negedge clock);
        reset = r; pc_esc = av; ifid_esc = av; br = b; bt = t; rdy = rd;
        #1;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        set_in(1, 1, 0, 0, 0); tick();
        set_in(1, 1, 0, 0, 0); tick();
    endtask

    task automatic test_reset();
        set_in(1, 1, 0, 0, 1); tick();
        set_in(1, 1, 0, 0, 1);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req got %b want 0", imem_req); end
        tick();
        n_cmp++; if (IFID_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %b want 0", IFID_valid); end
        n_cmp++; if (IFID_instr !== 32'h0) begin n_err++; $display("FAIL rst_instr got %h want 0", IFID_instr); end
        n_cmp++; if (IFID_pc4 !== 32'h0) begin n_err++; $display("FAIL rst_pc4 got %h want 0", IFID_pc4); end
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr got %h want 0", imem_addr); end
        n_cmp++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL rst_req1 got %b want 1", imem_req); end
        tick();
    endtask

    task automatic test_zero_wait();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 1, 0, 0, 1);
            n_cmp++; if (imem_addr !== 32'(4 * i)) begin n_err++; $display("FAIL zw_addr got %h want %h", imem_addr, 32'(4 * i)); end
            n_cmp++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL zw_stall got %b want 0", fetch_stall); end
            tick();
            n_cmp++; if (IFID_pc4 !== 32'(4 * i + 4)) begin n_err++; $display("FAIL zw_pc4 got %h want %h", IFID_pc4, 32'(4 * i + 4)); end
            n_cmp++; if (IFID_valid !== 1'b1) begin n_err++; $display("FAIL zw_valid got %b want 1", IFID_valid); end
            n_cmp++; if (IFID_instr !== mem_word(32'(4 * i))) begin n_err++; $display("FAIL zw_instr got %h want %h", IFID_instr, mem_word(32'(4 * i))); end
        end
    endtask

    task automatic test_wait_states();
        do_reset();
        for (int n = 0; n < 3; n++) begin
            for (int w = 0; w < 3; w++) begin
                set_in(0, 1, 0, 0, w == 2);
                n_cmp++; if (imem_addr !== 32'(4 * n)) begin n_err++; $display("FAIL ws_addr got %h want %h", imem_addr, 32'(4 * n)); end
                n_cmp++; if (fetch_stall !== (w != 2)) begin n_err++; $display("FAIL ws_stall got %b want %b", fetch_stall, w != 2); end
                tick();
                n_cmp++; if (IFID_valid !== (w == 2)) begin n_err++; $display("FAIL ws_valid got %b want %b", IFID_valid, w == 2); end
                n_cmp++; if (IFID_instr !== (w == 2 ? mem_word(32'(4 * n)) : 32'h0)) begin n_err++; $display("FAIL ws_instr got %h", IFID_instr); end
                n_cmp++; if (IFID_pc4 !== (w == 2 ? 32'(4 * n + 4) : 32'h0)) begin n_err++; $display("FAIL ws_pc4 got %h", IFID_pc4); end
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        set_in(0, 1, 0, 0, 1); tick();
        set_in(0, 1, 0, 0, 1); tick();
        set_in(0, 0, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'h8) begin n_err++; $display("FAIL st_addr got %h want 8", imem_addr); end
        tick();
        n_cmp++; if (IFID_pc4 !== 32'h8) begin n_err++; $display("FAIL st_hold1 got %h want 8", IFID_pc4); end
        set_in(0, 0, 0, 0, 1);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL st_req got %b want 0", imem_req); end
        n_cmp++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL st_fstall got %b want 0", fetch_stall); end
        tick();
        n_cmp++; if (IFID_pc4 !== 32'h8) begin n_err++; $display("FAIL st_hold2 got %h want 8", IFID_pc4); end
        set_in(0, 1, 0, 0, 1); tick();
        n_cmp++; if (IFID_pc4 !== 32'hC) begin n_err++; $display("FAIL st_rel_pc4 got %h want c", IFID_pc4); end
        n_cmp++; if (IFID_instr !== mem_word(32'h8)) begin n_err++; $display("FAIL st_rel_instr got %h want %h", IFID_instr, mem_word(32'h8)); end
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'hC || imem_req !== 1'b1) begin n_err++; $display("FAIL st_next got %h/%b want c/1", imem_addr, imem_req); end
        tick();
        n_cmp++; if (IFID_pc4 !== 32'h10) begin n_err++; $display("FAIL st_next_pc4 got %h want 10", IFID_pc4); end
    endtask

    task automatic test_branch();
        do_reset();
        set_in(0, 1, 0, 0, 1); tick();
        set_in(0, 1, 1, 32'h43, 1); tick();
        n_cmp++; if (IFID_valid !== 1'b0 || IFID_instr !== 32'h0) begin n_err++; $display("FAIL br_bubble got %b/%h want 0/0", IFID_valid, IFID_instr); end
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'h40) begin n_err++; $display("FAIL br_addr got %h want 40", imem_addr); end
        tick();
        n_cmp++; if (IFID_pc4 !== 32'h44 || IFID_valid !== 1'b1) begin n_err++; $display("FAIL br_pc4 got %h/%b want 44/1", IFID_pc4, IFID_valid); end
    endtask

    task automatic test_branch_pending();
        do_reset();
        set_in(0, 1, 1, 32'h10, 1); tick();
        set_in(0, 1, 0, 0, 0);
        n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL bp_addr0 got %h want 10", imem_addr); end
        tick();
        set_in(0, 1, 1, 32'h80, 0); tick();
        set_in(0, 1, 1, 32'h90, 0);
        n_cmp++; if (imem_addr !== 32'h10 || imem_req !== 1'b1) begin n_err++; $display("FAIL bp_hold got %h/%b want 10/1", imem_addr, imem_req); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL bp_stall got %b want 1", fetch_stall); end
        tick();
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'h10) begin n_err++; $display("FAIL bp_addr1 got %h want 10", imem_addr); end
        tick();
        n_cmp++; if (IFID_valid !== 1'b0 || IFID_instr !== 32'h0) begin n_err++; $display("FAIL bp_drop got %b/%h want 0/0", IFID_valid, IFID_instr); end
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'h90) begin n_err++; $display("FAIL bp_target got %h want 90", imem_addr); end
        tick();
        n_cmp++; if (IFID_pc4 !== 32'h94 || IFID_instr !== mem_word(32'h90)) begin n_err++; $display("FAIL bp_fetch got %h/%h want 94/%h", IFID_pc4, IFID_instr, mem_word(32'h90)); end
    endtask

    task automatic test_wrap_reset();
        do_reset();
        set_in(0, 1, 1, 32'hFFFF_FFFC, 1); tick();
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wr_addr got %h want fffffffc", imem_addr); end
        tick();
        n_cmp++; if (IFID_pc4 !== 32'h0 || IFID_valid !== 1'b1) begin n_err++; $display("FAIL wr_pc4 got %h/%b want 0/1", IFID_pc4, IFID_valid); end
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wr_next got %h want 0", imem_addr); end
        tick();
        set_in(0, 0, 0, 0, 1); tick();
        set_in(1, 0, 0, 0, 0);
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL wr_rreq got %b want 0", imem_req); end
        tick();
        set_in(0, 1, 0, 0, 1);
        n_cmp++; if (imem_addr !== 32'h0 || imem_req !== 1'b1 || IFID_valid !== 1'b0) begin n_err++; $display("FAIL wr_rst got %h/%b/%b want 0/1/0", imem_addr, imem_req, IFID_valid); end
        tick();
        n_cmp++; if (IFID_pc4 !== 32'h4 || IFID_valid !== 1'b1) begin n_err++; $display("FAIL wr_after got %h/%b want 4/1", IFID_pc4, IFID_valid); end
    endtask

    task automatic test_random();
        logic        pend;
        logic [31:0] paddr;
        pend = 0; paddr = 0;
        for (int c = 0; c < 600; c++) begin
            set_in($urandom_range(0, 49) == 0, $urandom_range(0, 4) != 0, $urandom_range(0, 9) == 0,
                   $urandom, $urandom_range(0, 9) < 6);
            n_cmp++; if (imem_req !== (!reset && !m_buf)) begin n_err++; $display("FAIL rnd_req cyc %0d got %b want %b", c, imem_req, !reset && !m_buf); end
            n_cmp++; if (imem_addr !== m_addr) begin n_err++; $display("FAIL rnd_addr cyc %0d got %h want %h", c, imem_addr, m_addr); end
            n_cmp++; if (fetch_stall !== (m_drop || (!m_buf && !rdy))) begin n_err++; $display("FAIL rnd_fstall cyc %0d got %b", c, fetch_stall); end
            n_cmp++; if (IFID_rs !== m_instr[25:21] || IFID_rt !== m_instr[20:16]) begin n_err++; $display("FAIL rnd_rsrt cyc %0d got %h/%h", c, IFID_rs, IFID_rt); end
            if (pend) begin
                n_cmp++; if (imem_addr !== paddr) begin n_err++; $display("FAIL rnd_stable cyc %0d got %h want %h", c, imem_addr, paddr); end
            end
            pend = imem_req === 1'b1 && !rdy;
            paddr = imem_addr;
            tick();
            n_cmp++; if (IFID_instr !== m_instr || IFID_pc4 !== m_pc4 || IFID_valid !== m_valid) begin
                n_err++; $display("FAIL rnd_ifid cyc %0d got %h/%h/%b want %h/%h/%b", c, IFID_instr, IFID_pc4, IFID_valid, m_instr, m_pc4, m_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait_states();
        test_stall();
        test_branch();
        test_branch_pending();
        test_wrap_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
